instr_decode_queue: RTL

Parametrised successor to the combinational instruction field splitter. Buffers fetched MIPS instructions, with their PCs, in a DEPTH-entry FIFO between the IF and ID stages. Presents the head entry already split into fields, with a 32-bit extended immediate. Provides a valid/ready handshake on both sides and a flush for branch/exception redirect.

---
 rtl/instr_decode_queue.sv | 117 +++++++++++
 1 files changed

// File: rtl/instr_decode_queue.sv
// IF/ID instruction queue: buffers fetched MIPS words with their PCs
// and presents the head entry already split into decode fields.
module instr_decode_queue #(
  parameter  int DEPTH = 4,
  parameter  int PC_W  = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       func,
  output logic [15:0]      imm16,
  output logic [25:0]      imm26,
  output logic [31:0]      imm32,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;

  logic [31:0]      mem_instr [DEPTH];
  logic [PC_W-1:0]  mem_pc    [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CNT_W-1:0] cnt;

  logic push;
  logic pop;
  logic clr;

  assign in_ready  = (cnt != CNT_W'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign clr       = reset | flush;
  assign count     = cnt;

  // Redirect discards entries logically; the storage itself is left alone.
  always_ff @(posedge clk) begin
    if (clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem_instr[wp] <= in_instr;
      mem_pc[wp]    <= in_pc;
    end
  end

  logic [31:0]     head;
  logic [PC_W-1:0] head_pc;

  // Empty queue drives all-zero fields, so nothing stale leaks to ID.
  always_comb begin
    head    = '0;
    head_pc = '0;
    if (out_valid) begin
      head    = mem_instr[rp];
      head_pc = mem_pc[rp];
    end
  end

  assign out_pc = head_pc;
  assign opcode = head[31:26];
  assign rs     = head[25:21];
  assign rt     = head[20:16];
  assign rd     = head[15:11];
  assign shamt  = head[10:6];
  assign func   = head[5:0];
  assign imm16  = head[15:0];
  assign imm26  = head[25:0];

  logic is_zx;
  logic is_lui;

  assign is_zx  = (opcode == OP_ANDI) || (opcode == OP_ORI) ||
                  (opcode == OP_XORI);
  assign is_lui = (opcode == OP_LUI);

  always_comb begin
    imm32 = '0;
    unique case (1'b1)
      is_zx:   imm32 = {16'h0, imm16};
      is_lui:  imm32 = {imm16, 16'h0};
      default: imm32 = {{16{imm16[15]}}, imm16};
    endcase
  end

endmodule
